// File: rtl/cycle_sequencer.sv
// M-cycle / T-cycle sequencer with start-up hold and sticky count error.
// Optional memory wait states enabled by defining CYCLE_SEQ_STALL_EN.
module cycle_sequencer #(
  parameter  int T_PER_M = 4,
  parameter  int M_MAX   = 6,
  localparam int TW      = $clog2(T_PER_M),
  localparam int MW      = $clog2(M_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MW-1:0] m_count_in,
  input  logic          m_extend,
  input  logic          stall,
  output logic [MW-1:0] m_cycle,
  output logic [TW-1:0] t_cycle,
  output logic          m1t1,
  output logic          t_last,
  output logic          m_last,
  output logic          fetch_rd,
  output logic          hold,
  output logic          instr_done,
  output logic          cnt_err
);

`ifdef CYCLE_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_WAIT
  } state_t;

  state_t        st_q, st_d;
  logic [TW-1:0] t_q, t_d;
  logic [MW-1:0] m_q, m_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          adv;
  logic          ld;
  logic          bad;
  logic          ext;

  assign m_cycle    = m_q;
  assign t_cycle    = t_q;
  assign m1t1       = (m_q == '0) && (t_q == '0);
  assign t_last     = t_q == TW'(T_PER_M - 1);
  assign m_last     = m_q == cnt_q - MW'(1);
  assign fetch_rd   = m_last && (t_q == TW'(T_PER_M - 2));
  assign hold       = st_q == S_HOLD;
  assign instr_done = t_last && m_last && (st_q == S_RUN);
  assign cnt_err    = err_q;

  // Stall is only sampled on T2 of a running M-cycle.
  always_comb begin
    st_d = st_q;
    adv  = 1'b1;
    unique case (st_q)
      S_HOLD: begin
        if (t_last) st_d = S_RUN;
      end
      S_RUN: begin
        if (STALL_EN && stall && t_q == TW'(1)) begin
          st_d = S_WAIT;
          adv  = 1'b0;
        end
      end
      S_WAIT: begin
        adv = !stall;
        if (!stall) st_d = S_RUN;
      end
      default: st_d = S_HOLD;
    endcase
  end

  always_comb begin
    t_d = t_q;
    m_d = m_q;
    if (adv) begin
      if (t_last) begin
        t_d = '0;
        m_d = m_last ? '0 : m_q + MW'(1);
      end else begin
        t_d = t_q + TW'(1);
      end
    end
  end

  assign ld  = m1t1 && (st_q == S_RUN);
  assign bad = (m_count_in == '0) || (m_count_in > MW'(M_MAX));
  assign ext = (st_q == S_RUN) && m_extend && m_last && !t_last && !ld;

  // A fresh load at M1T1 takes priority over a late extension request.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (st_q == S_HOLD) begin
      cnt_d = MW'(1);
    end else if (ld) begin
      cnt_d = bad ? MW'(1) : m_count_in;
      if (bad) err_d = 1'b1;
    end else if (ext) begin
      if (cnt_q == MW'(M_MAX)) err_d = 1'b1;
      else cnt_d = cnt_q + MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_HOLD;
      t_q   <= '0;
      m_q   <= '0;
      cnt_q <= MW'(1);
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      t_q   <= t_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer at T_PER_M=4, M_MAX=6.
// Stall scenarios follow CYCLE_SEQ_STALL_EN when it is defined.
module tb_cycle_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] m_count_in = 3'd1;
  logic       m_extend = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] m_cycle;
  logic [1:0] t_cycle;
  logic       m1t1, t_last, m_last, fetch_rd;
  logic       hold, instr_done, cnt_err;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cycle_sequencer #(.T_PER_M(4), .M_MAX(6)) dut (
    .clk(clk),
    .rst(rst),
    .m_count_in(m_count_in),
    .m_extend(m_extend),
    .stall(stall),
    .m_cycle(m_cycle),
    .t_cycle(t_cycle),
    .m1t1(m1t1),
    .t_last(t_last),
    .m_last(m_last),
    .fetch_rd(fetch_rd),
    .hold(hold),
    .instr_done(instr_done),
    .cnt_err(cnt_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_m", m_cycle, 0);
    chk("rst_t", t_cycle, 0);
    chk("rst_m1t1", m1t1, 1);
    chk("rst_m_last", m_last, 1);
    chk("rst_hold", hold, 1);
    chk("rst_t_last", t_last, 0);
    chk("rst_fetch", fetch_rd, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_err", cnt_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_extend = 1'b0;
    stall = 1'b0;
    step();
    chk_reset();
    rst = 1'b0;
  endtask

  task automatic hold_phase();
    for (int t = 0; t < 4; t++) begin
      chk("hold_t", t_cycle, t);
      chk("hold_m", m_cycle, 0);
      chk("hold", hold, 1);
      chk("hold_done", instr_done, 0);
      step();
    end
  endtask

  // One instruction from its M1T1; optional m_extend pulse at (em, et).
  task automatic instr(input int ld, input int em, input int et,
                       input bit eok);
    int cnt;
    int mm;
    int tt;
    cnt = (ld == 0 || ld > 6) ? 1 : ld;
    mm = 0;
    tt = 0;
    m_count_in = 3'(ld);
    for (int k = 0; k < 64; k++) begin
      chk("m_cycle", m_cycle, mm);
      chk("t_cycle", t_cycle, tt);
      chk("m1t1", m1t1, (mm == 0 && tt == 0));
      chk("t_last", t_last, (tt == 3));
      chk("fetch_rd", fetch_rd, (mm == cnt - 1 && tt == 2));
      chk("instr_done", instr_done, (mm == cnt - 1 && tt == 3));
      chk("run_hold", hold, 0);
      if (!(mm == 0 && tt == 0))
        chk("m_last", m_last, (mm == cnt - 1));
      m_extend = (mm == em && tt == et);
      step();
      m_extend = 1'b0;
      if (mm == em && tt == et && eok) cnt++;
      if (tt == 3) begin
        if (mm == cnt - 1) break;
        tt = 0;
        mm++;
      end else begin
        tt++;
      end
    end
  endtask

  initial begin
    do_reset();
    hold_phase();
    instr(1, -1, -1, 0);
    instr(1, -1, -1, 0);
    instr(3, -1, -1, 0);
    instr(2, 1, 1, 1);
    instr(2, 1, 3, 0);
    chk("err_after_late_ext", cnt_err, 0);
    instr(1, 0, 1, 1);
    instr(2, 0, 1, 0);
    chk("err_after_early_ext", cnt_err, 0);
    instr(0, -1, -1, 0);
    chk("err_zero_count", cnt_err, 1);
    instr(2, -1, -1, 0);
    chk("err_sticky", cnt_err, 1);

    do_reset();
    hold_phase();
    instr(6, 5, 1, 0);
    chk("err_ext_at_max", cnt_err, 1);
    instr(7, -1, -1, 0);
    chk("err_over_max", cnt_err, 1);

`ifdef CYCLE_SEQ_STALL_EN
    do_reset();
    hold_phase();
    m_count_in = 3'd3;
    chk("st_m1t1", m1t1, 1);
    step();
    chk("st_t1", t_cycle, 1);
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("st_frozen_t", t_cycle, 1);
      chk("st_frozen_m", m_cycle, 0);
      chk("st_done", instr_done, 0);
      if (i == 5) stall = 1'b0;
    end
    step();
    chk("st_resume_t", t_cycle, 2);
    stall = 1'b1;
    step();
    chk("st_t2_ignored", t_cycle, 3);
    stall = 1'b0;
    step();
    chk("st_m1", m_cycle, 1);
    chk("st_m1_t", t_cycle, 0);
    for (int i = 0; i < 5; i++) step();
    chk("st_m2_t1", t_cycle, 1);
    chk("st_m2", m_cycle, 2);
    stall = 1'b1;
    step();
    step();
    chk("st_wait_t", t_cycle, 1);
    chk("st_wait_m", m_cycle, 2);
    rst = 1'b1;
    m_extend = 1'b1;
    step();
    chk_reset();
    rst = 1'b0;
    m_extend = 1'b0;
    stall = 1'b0;
`else
    stall = 1'b1;
    instr(3, -1, -1, 0);
    instr(2, -1, -1, 0);
    stall = 1'b0;
    m_count_in = 3'd3;
    for (int i = 0; i < 9; i++) step();
    chk("mid_m", m_cycle, 2);
    chk("mid_t", t_cycle, 1);
    rst = 1'b1;
    m_extend = 1'b1;
    stall = 1'b1;
    step();
    chk_reset();
    rst = 1'b0;
    m_extend = 1'b0;
    stall = 1'b0;
`endif
    hold_phase();
    instr(2, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameter T_PER_M, default 4, T-cycles per M-cycle; legal 2..8.
REQ-002 Parameter M_MAX, default 6, max M-cycles per instruction; legal 1..15.
REQ-003 Derived widths: TW = clog2(T_PER_M); MW = clog2(M_MAX+1).
REQ-004 One clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 m_count_in  in  MW  M-cycle count of the instruction in the instruction register, from decode.
REQ-008 m_extend  in  1  request one extra M-cycle for the current instruction (conditional taken paths).
REQ-009 stall  in  1  memory wait-state request.
REQ-010 m_cycle  out  MW  current M-cycle index, 0 = M1.
REQ-011 t_cycle  out  TW  current T-cycle index, 0 = T1.
REQ-012 m1t1  out  1  high when m_cycle==0 and t_cycle==0; opcode fetch latch strobe.
REQ-013 t_last  out  1  high when t_cycle==T_PER_M-1; register writeback strobe.
REQ-014 m_last  out  1  high when m_cycle==m_count_q-1.
REQ-015 fetch_rd  out  1  high when m_last and t_cycle==T_PER_M-2; reads next opcode.
REQ-016 hold  out  1  start-up hold; decode suppresses side effects while high.
REQ-017 instr_done  out  1  one-clock pulse at final T-cycle of an instruction.
REQ-018 cnt_err  out  1  sticky illegal-count flag.

Function
REQ-019 Registered state: t counter, m counter, m_count_q, FSM {HOLD, RUN, WAIT}, cnt_err; all other outputs are combinational decodes of these, zero added latency.
REQ-020 In HOLD/RUN with no stall, t increments by 1 per clock; at T_PER_M-1 it wraps to 0 and m increments; if m_last, m wraps to 0.
REQ-021 m_count_q is loaded from m_count_in on every clock where m1t1 is high and the FSM is not in WAIT.
REQ-022 If m_count_in is 0 or greater than M_MAX at load, m_count_q loads 1 and cnt_err sets; cnt_err clears only on rst.
REQ-023 m_count_q==1 gives back-to-back single-M-cycle instructions, m_cycle constantly 0.
REQ-024 m_extend is honoured only when m_last is high and t_last is low; m_count_q increments by 1, so m_last deasserts.
REQ-025 m_extend with m_count_q==M_MAX is ignored and sets cnt_err; m_extend when not m_last, or with t_last high, is ignored with no flag.
REQ-026 Only one extension per clock; multiple extensions in successive M-cycles are legal up to M_MAX.
REQ-027 FSM HOLD: entered on rst; m_count_q forced to 1; hold=1; on t_last go to RUN. instr_done suppressed in HOLD.
REQ-028 FSM RUN to WAIT: stall high while t_cycle==1; counters freeze at t_cycle==1.
REQ-029 FSM WAIT: counters frozen, all outputs static; when stall is low, t advances to 2 on that same clock and FSM returns to RUN.
REQ-030 stall at any t_cycle other than 1 is ignored; HOLD ignores stall.
REQ-031 instr_done = t_last and m_last and FSM==RUN.
REQ-032 When T_PER_M==2, fetch_rd coincides with t_cycle==0 of the last M-cycle.

Reset
REQ-033 On rst: t=0, m=0, m_count_q=1, FSM=HOLD, cnt_err=0.
REQ-034 Resulting output values: m_cycle=0, t_cycle=0, m1t1=1, m_last=1, hold=1, t_last=0, fetch_rd=0, instr_done=0.
REQ-035 rst overrides stall, m_extend and WAIT in the same clock, including mid-instruction.

Configuration
REQ-036 Macro CYCLE_SEQ_STALL_EN: when defined, REQ-028..REQ-030 apply and the WAIT state exists.
REQ-037 When CYCLE_SEQ_STALL_EN is undefined, the stall input is ignored, WAIT is never entered, and counters always advance.

Verification
REQ-038 T_PER_M=4, release rst, m_count_in=1 -> hold high for clocks 0-3; t sequence 0,1,2,3,0; first instr_done at clock 7; m1t1 every 4 clocks.
REQ-039 m_count_in=3 at M1T1 -> m_cycle 0,1,2 over 12 clocks; fetch_rd only at m=2,t=2; instr_done at m=2,t=3.
REQ-040 m_count_q=2, m_extend pulse at m=1,t=1 -> 3 M-cycles, instr_done at m=2,t=3; repeat at m=1,t=3 -> ignored, 2 M-cycles, cnt_err=0.
REQ-041 STALL_EN defined, stall high 5 clocks from t=1 of M1 -> t holds 1 for 6 clocks, then 2; instruction length 4+5 clocks; stall at t=2 -> no effect.
REQ-042 m_count_in=0 -> single M-cycle, cnt_err=1 until rst; M_MAX=6, m_count_q=6, m_extend on last M -> cnt_err=1, length unchanged.
REQ-043 rst asserted during WAIT at m=2 -> next clock all outputs at REQ-034 values.
